// File: rtl/fp_exception_unit_if.sv
// rtl/fp_exception_unit_if.sv - result channel between rounding stage, exception unit and writeback
interface fp_exception_unit_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   // upstream side: pre-exception result and datapath status
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] z;
   logic         neg_e;
   logic         r;
   logic         s;
   logic [4:0]   input_exc;
   logic         eof;
   logic [1:0]   rnd_mode;

   // downstream side: final result and per-result flags
   logic         p_valid;
   logic         p_ready;
   logic [W-1:0] p;
   logic [4:0]   flags;

   modport master (
      output in_valid, z, neg_e, r, s, input_exc, eof, rnd_mode, p_ready,
      input  in_ready, p_valid, p, flags
   );

   modport slave (
      input  in_valid, z, neg_e, r, s, input_exc, eof, rnd_mode, p_ready,
      output in_ready, p_valid, p, flags
   );
endinterface

// File: rtl/fp_exception_unit.sv
// rtl/fp_exception_unit.sv - IEEE-754 special-value substitution, flags, sticky status and exception counter
module fp_exception_unit #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   fp_exception_unit_if.slave bus,
   input  logic             flag_clr,
   output logic [4:0]       sticky_flags,
   output logic [CNT_W-1:0] exc_count
);
   localparam int W = 1 + EXP_W + MAN_W;

   // flag bit positions
   localparam int F_OVF = 4;
   localparam int F_UNF = 3;
   localparam int F_INV = 1;
   localparam int F_NX  = 0;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   logic [W-1:0]     p_q, p_d;
   logic [4:0]       flags_q, flags_d;
   logic             p_valid_q, p_valid_d;
   logic [4:0]       sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             xfer;
   logic             sign;
   logic [W-1:0]     qnan;
   logic [W-1:0]     inf_val;
   logic [W-1:0]     max_val;
   logic             ovf_to_inf;
   logic [W-1:0]     res;
   logic [4:0]       res_flags;
   logic [4:0]       xfer_flags;
   logic             qualifies;

   assign bus.in_ready = ~p_valid_q | bus.p_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign xfer         = p_valid_q & bus.p_ready;

   assign sign    = bus.z[W-1];
   assign qnan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   assign inf_val = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   assign max_val = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

   // directed rounding modes saturate to max finite when rounding away from infinity
   always_comb begin
      ovf_to_inf = 1'b1;
      case (bus.rnd_mode)
         RM_RNE:  ovf_to_inf = 1'b1;
         RM_RTZ:  ovf_to_inf = 1'b0;
         RM_RUP:  ovf_to_inf = ~sign;
         RM_RDN:  ovf_to_inf = sign;
         default: ovf_to_inf = 1'b1;
      endcase
   end

   always_comb begin
      res       = bus.z;
      res_flags = 5'b00000;
      if (|bus.input_exc[4:2]) begin
         res            = qnan;
         res_flags[F_INV] = 1'b1;
      end else if (|bus.input_exc[1:0]) begin
         res = inf_val;
      end else if (bus.eof) begin
         res              = ovf_to_inf ? inf_val : max_val;
         res_flags[F_OVF] = 1'b1;
         res_flags[F_NX]  = 1'b1;
      end else if (bus.neg_e & (bus.r | bus.s)) begin
         res              = {sign, {(W-1){1'b0}}};
         res_flags[F_UNF] = 1'b1;
         res_flags[F_NX]  = 1'b1;
      end else begin
         res             = bus.z;
         res_flags[F_NX] = bus.r | bus.s;
      end
   end

   always_comb begin
      p_d       = p_q;
      flags_d   = flags_q;
      p_valid_d = p_valid_q;
      if (accept) begin
         p_d       = res;
         flags_d   = res_flags;
         p_valid_d = 1'b1;
      end else if (xfer) begin
         p_valid_d = 1'b0;
      end
   end

   // a clear coinciding with a transfer clears first, then records that transfer
   always_comb begin
      xfer_flags = xfer ? flags_q : 5'b00000;
      qualifies  = xfer & (|flags_q[4:1]);
      sticky_d   = flag_clr ? xfer_flags : (sticky_q | xfer_flags);
      cnt_d      = cnt_q;
      if (flag_clr) begin
         cnt_d = qualifies ? CNT_W'(1) : '0;
      end else if (qualifies && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q       <= '0;
         flags_q   <= '0;
         p_valid_q <= 1'b0;
         sticky_q  <= '0;
         cnt_q     <= '0;
      end else begin
         p_q       <= p_d;
         flags_q   <= flags_d;
         p_valid_q <= p_valid_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.p       = p_q;
   assign bus.flags   = flags_q;
   assign bus.p_valid = p_valid_q;
   assign sticky_flags = sticky_q;
   assign exc_count    = cnt_q;
endmodule

// File: tb/tb_fp_exception_unit.sv
// tb/tb_fp_exception_unit.sv - scoreboard bench for fp_exception_unit against an IEEE-level reference model
module tb_fp_exception_unit;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flag_clr = 1'b0;
   logic [4:0]  sticky_flags;
   logic [4:0]  sticky_flags2;
   logic [15:0] exc_count;
   logic [1:0]  exc_count2;

   fp_exception_unit_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
   fp_exception_unit_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus2 ();

   // second instance with a 2-bit counter sees identical traffic
   assign bus2.in_valid  = bus.in_valid;
   assign bus2.z         = bus.z;
   assign bus2.neg_e     = bus.neg_e;
   assign bus2.r         = bus.r;
   assign bus2.s         = bus.s;
   assign bus2.input_exc = bus.input_exc;
   assign bus2.eof       = bus.eof;
   assign bus2.rnd_mode  = bus.rnd_mode;
   assign bus2.p_ready   = bus.p_ready;

   fp_exception_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .flag_clr(flag_clr),
      .sticky_flags(sticky_flags), .exc_count(exc_count)
   );

   fp_exception_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave), .flag_clr(flag_clr),
      .sticky_flags(sticky_flags2), .exc_count(exc_count2)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: IEEE-754 single precision rules, result in [36:5], flags in [4:0]
   function automatic logic [36:0] model(input logic [31:0] z, input logic neg_e, input logic r,
                                         input logic s, input logic [4:0] exc, input logic eof,
                                         input logic [1:0] mode);
      logic neg;
      logic to_inf;
      neg = z[31];
      if (exc[4:2] != 3'b000) return {32'h7FC00000, 5'b00010};
      if (exc[1:0] != 2'b00)  return {(neg ? 32'hFF800000 : 32'h7F800000), 5'b00000};
      if (eof) begin
         case (mode)
            2'd0:    to_inf = 1'b1;
            2'd1:    to_inf = 1'b0;
            2'd2:    to_inf = !neg;
            default: to_inf = neg;
         endcase
         if (neg) return {(to_inf ? 32'hFF800000 : 32'hFF7FFFFF), 5'b10001};
         else     return {(to_inf ? 32'h7F800000 : 32'h7F7FFFFF), 5'b10001};
      end
      if (neg_e && (r || s)) return {(neg ? 32'h80000000 : 32'h00000000), 5'b01001};
      return {z, 4'b0000, (r | s)};
   endfunction

   logic [36:0] sb_q[$];
   logic [4:0]  m_sticky = 5'b0;
   int          m_cnt  = 0;
   int          m_cnt2 = 0;
   logic        m_valid;
   logic        m_accept;
   logic        m_xfer;
   logic [36:0] m_front;
   logic [4:0]  m_xflags;

   // monitor: samples mid-cycle, compares, then advances the model to the next edge
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
         m_sticky = 5'b0;
         m_cnt    = 0;
         m_cnt2   = 0;
         check("rst_p_valid", 64'(bus.p_valid), 64'd0);
         check("rst_in_ready", 64'(bus.in_ready), 64'd1);
         check("rst_p", 64'(bus.p), 64'd0);
         check("rst_flags", 64'(bus.flags), 64'd0);
         check("rst_sticky", 64'(sticky_flags), 64'd0);
         check("rst_count", 64'(exc_count), 64'd0);
         check("rst_count2", 64'(exc_count2), 64'd0);
      end else begin
         m_valid = (sb_q.size() != 0);
         check("p_valid", 64'(bus.p_valid), 64'(m_valid));
         check("in_ready", 64'(bus.in_ready), 64'(!m_valid || bus.p_ready));
         check("sticky", 64'(sticky_flags), 64'(m_sticky));
         check("exc_count", 64'(exc_count), 64'(m_cnt));
         check("exc_count_sat", 64'(exc_count2), 64'(m_cnt2));
         m_front = m_valid ? sb_q[0] : 37'd0;
         if (m_valid) begin
            check("p", 64'(bus.p), 64'(m_front[36:5]));
            check("flags", 64'(bus.flags), 64'(m_front[4:0]));
            check("p_inst2", 64'(bus2.p), 64'(m_front[36:5]));
         end
         m_xfer   = m_valid && bus.p_ready;
         m_accept = bus.in_valid && (!m_valid || bus.p_ready);
         m_xflags = m_xfer ? m_front[4:0] : 5'b0;
         if (m_xfer) void'(sb_q.pop_front());
         if (m_accept)
            sb_q.push_back(model(bus.z, bus.neg_e, bus.r, bus.s, bus.input_exc, bus.eof, bus.rnd_mode));
         m_sticky = flag_clr ? m_xflags : (m_sticky | m_xflags);
         if (flag_clr) begin
            m_cnt  = (m_xflags[4:1] != 0) ? 1 : 0;
            m_cnt2 = m_cnt;
         end else if (m_xflags[4:1] != 0) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
   end

   task automatic drive(input logic [31:0] z, input logic ne, input logic r, input logic s,
                        input logic [4:0] exc, input logic eof, input logic [1:0] mode);
      bus.z = z; bus.neg_e = ne; bus.r = r; bus.s = s;
      bus.input_exc = exc; bus.eof = eof; bus.rnd_mode = mode;
   endtask

   task automatic tick(input logic iv, input logic pr, input logic clr);
      bus.in_valid = iv;
      bus.p_ready  = pr;
      flag_clr     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      int c;
      c = $urandom_range(0, 5);
      drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 5'b0, 1'b0, 2'($urandom));
      case (c)
         0: bus.input_exc = 5'($urandom);
         1: bus.input_exc = {3'b000, 2'($urandom)};
         2: bus.eof = 1'b1;
         3: bus.eof = 1'($urandom);
         default: bus.neg_e = 1'($urandom);
      endcase
   endtask

   initial begin
      drive(32'h0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 2'b00);
      bus.in_valid = 1'b0;
      bus.p_ready  = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      drive(32'h3F800000, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 2'b00);
      tick(1'b1, 1'b1, 1'b0);
      for (int m = 0; m < 4; m++) begin
         drive(32'hC0000000, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1, 2'(m));
         tick(1'b1, 1'b1, 1'b0);
      end
      drive(32'h12345678, 1'b1, 1'b1, 1'b0, 5'b00100, 1'b1, 2'b00);
      tick(1'b1, 1'b1, 1'b0);
      drive(32'h7F800000, 1'b0, 1'b0, 1'b0, 5'b00010, 1'b0, 2'b00);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1);

      drive(32'h00400000, 1'b1, 1'b1, 1'b0, 5'b0, 1'b0, 2'b00);
      tick(1'b1, 1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0);
      check("dir_sticky_unf", 64'(sticky_flags), 64'h09);
      drive(32'hC0000000, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1, 2'b00);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b1, 1'b1);
      check("dir_sticky_collide", 64'(sticky_flags), 64'h11);
      check("dir_count_collide", 64'(exc_count), 64'd1);

      repeat (5) begin
         drive(32'h42000000, 1'b0, 1'b0, 1'b0, 5'b0, 1'b1, 2'b00);
         tick(1'b1, 1'b1, 1'b0);
      end
      tick(1'b0, 1'b1, 1'b0);
      check("dir_count_sat", 64'(exc_count2), 64'd3);

      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0));
      end
      repeat (3) tick(1'b0, 1'b1, 1'b0);
      check("drain_empty", 64'(sb_q.size()), 64'd0);

      rand_inputs();
      tick(1'b1, 1'b0, 1'b0);
      check("pre_rst_p_valid", 64'(bus.p_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("async_rst_p_valid", 64'(bus.p_valid), 64'd0);
      check("async_rst_sticky", 64'(sticky_flags), 64'd0);
      check("async_rst_count", 64'(exc_count), 64'd0);
      tick(1'b0, 1'b1, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 100; i++) begin
         rand_inputs();
         tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0));
      end
      repeat (3) tick(1'b0, 1'b1, 1'b0);
      check("final_drain_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
